// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter that merges N_REQ AXI-Stream requesters onto one output stream.
// A grant is held for a whole packet, or in burst mode until a beat limit or an idle cycle.
module axis_rr_arbiter #(
  parameter int DWIDTH    = 32,
  parameter int N_REQ     = 4,
  parameter int PKT_MODE  = 1,
  parameter int MAX_BURST = 16,
  localparam int IW       = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DWIDTH-1:0] s_axis_tdata,
  input  logic [N_REQ-1:0]        s_axis_tvalid,
  input  logic [N_REQ-1:0]        s_axis_tlast,
  output logic [N_REQ-1:0]        s_axis_tready,
  output logic [DWIDTH-1:0]       m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [IW-1:0]           m_axis_tid,
  input  logic                    m_axis_tready,
  output logic                    grant_vld,
  output logic [IW-1:0]           grant_id
);

  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [IW-1:0]   grant_id_reg, grant_id_next;
  logic [BW-1:0]   beat_cnt_reg, beat_cnt_next;

  logic [DWIDTH-1:0] req_data [N_REQ];
  logic [IW-1:0]     ptr_inc;
  logic [IW-1:0]     search_base;
  logic [IW-1:0]     pick;
  logic              any_req;
  logic              owner_valid;
  logic              owner_last;
  logic              beat_acc;
  logic              release_grant;
  int                off;
  int                best_off;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_data[gi]      = s_axis_tdata[gi*DWIDTH +: DWIDTH];
      assign s_axis_tready[gi] = (state_reg == GRANT) && (grant_id_reg == IW'(gi)) && m_axis_tready;
    end
  endgenerate

  assign any_req     = |s_axis_tvalid;
  assign owner_valid = s_axis_tvalid[grant_id_reg];
  assign owner_last  = s_axis_tlast[grant_id_reg];
  assign beat_acc    = (state_reg == GRANT) && owner_valid && m_axis_tready;
  assign ptr_inc     = (grant_id_reg == IW'(N_REQ - 1)) ? '0 : grant_id_reg + IW'(1);
  // In GRANT the pick is only used on release, so the search starts just past the owner.
  assign search_base = (state_reg == GRANT) ? ptr_inc : ptr_reg;

  always_comb begin
    pick     = '0;
    best_off = N_REQ;
    off      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      off = (i + N_REQ - int'(search_base)) % N_REQ;
      if (s_axis_tvalid[i] && (off < best_off)) begin
        best_off = off;
        pick     = IW'(i);
      end
    end
  end

  always_comb begin
    release_grant = 1'b0;
    if (state_reg == GRANT) begin
      if (PKT_MODE != 0)
        release_grant = beat_acc && owner_last;
      else
        release_grant = (beat_acc && (owner_last || (beat_cnt_reg == BURST_LAST))) || !owner_valid;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    grant_id_next = grant_id_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next    = GRANT;
          grant_id_next = pick;
          beat_cnt_next = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          ptr_next      = ptr_inc;
          beat_cnt_next = '0;
          if (any_req)
            grant_id_next = pick;
          else
            state_next = IDLE;
        end else if (beat_acc && (beat_cnt_reg != '1)) begin
          beat_cnt_next = beat_cnt_reg + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      grant_id_reg <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      grant_id_reg <= grant_id_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  assign m_axis_tdata  = req_data[grant_id_reg];
  assign m_axis_tlast  = owner_last;
  assign m_axis_tvalid = (state_reg == GRANT) && owner_valid;
  assign m_axis_tid    = grant_id_reg;
  assign grant_vld     = (state_reg == GRANT);
  assign grant_id      = grant_id_reg;

endmodule
